// File: rtl/apb_id_pkg.sv
// Shared address map, bus FSM states and ID table helper for the APB ID bank.
package apb_id_pkg;

  localparam logic [11:0] ID_OFS      = 12'h000;
  localparam logic [11:0] CTRL_OFS    = 12'h100;
  localparam logic [11:0] SCRATCH_OFS = 12'h104;
  localparam logic [11:0] RO_OFS      = 12'h108;
  localparam logic [11:0] STATUS_OFS  = 12'h10C;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

  typedef enum logic [2:0] {
    SEL_NONE, SEL_ID, SEL_CTRL, SEL_SCRATCH, SEL_RO, SEL_STATUS
  } reg_sel_e;

  function automatic logic [31:0] id_value(input logic [31:0] base,
                                           input logic [31:0] c,
                                           input logic [31:0] i);
    return base + (c << 4) + i;
  endfunction

endpackage

// File: rtl/id_channel.sv
// One ID sequence pointer: loadable, optionally auto-advancing, pulses wrap at DEPTH-1.
module id_channel #(
  parameter int DEPTH = 10,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [PW-1:0] load_val,
  input  logic          advance,
  output logic [PW-1:0] ptr,
  output logic          wrap
);

  assign wrap = advance && (ptr == PW'(DEPTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (advance) begin
      ptr <= wrap ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/apb_id_bank.sv
// APB3 register bank: NUM_CH ID-sequence channels plus CTRL, SCRATCH, RO and STATUS.
module apb_id_bank
  import apb_id_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          DEPTH       = 10,
  parameter logic [31:0] ID_BASE     = 32'hA0,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] R_VALUE     = 32'h00FF0000,
  parameter logic [31:0] W_RESET     = 32'h00CCCAA0
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PSEL,
  input  logic        PENABLE,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam int PW = $clog2(DEPTH);

  apb_state_e state, state_nxt;
  logic [2:0]  cnt;
  logic        ready, complete, wr_ok;
  reg_sel_e    sel, sel_q;
  logic [2:0]  ch, ch_q;
  logic        err, err_q, write_q;
  logic [31:0] rval, rdata_q, scratch;
  logic [11:0] off, id_rel;
  logic [NUM_CH-1:0] ctrl, status, load, advance, wrap;
  logic [NUM_CH-1:0][PW-1:0] ptrs;
  logic [PW-1:0] load_val;
  logic        id_ovf;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^PADDR[31:12];

  // Address decode and read-value selection, sampled into the *_q registers in SETUP.
  always_comb begin
    off    = PADDR[11:0];
    id_rel = off - ID_OFS;
    ch     = id_rel[4:2];
    sel    = SEL_NONE;
    if (id_rel < 12'(4 * NUM_CH)) begin
      sel = SEL_ID;
    end else begin
      case (off)
        CTRL_OFS:    sel = SEL_CTRL;
        SCRATCH_OFS: sel = SEL_SCRATCH;
        RO_OFS:      sel = SEL_RO;
        STATUS_OFS:  sel = SEL_STATUS;
        default:     sel = SEL_NONE;
      endcase
    end
    err = (sel == SEL_NONE) || (off[1:0] != 2'b00) || ((sel == SEL_RO) && PWRITE);

    rval = '0;
    case (sel)
      SEL_ID: begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if (ch == 3'(c)) rval = id_value(ID_BASE, c, 32'(ptrs[c]));
        end
      end
      SEL_CTRL:    rval = 32'(ctrl);
      SEL_SCRATCH: rval = scratch;
      SEL_RO:      rval = R_VALUE;
      SEL_STATUS:  rval = 32'(status);
      default:     rval = '0;
    endcase
    if (err) rval = '0;
  end

  assign ready    = (state == ACCESS) && (cnt == 3'(WAIT_STATES));
  assign complete = ready && PSEL;
  assign wr_ok    = complete && write_q && !err_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (PSEL && !PENABLE) state_nxt = SETUP;
      SETUP:   state_nxt = PSEL ? ACCESS : IDLE;
      // Completion heads straight to SETUP so a back-to-back setup phase is captured.
      ACCESS: begin
        if (!PSEL)      state_nxt = IDLE;
        else if (ready) state_nxt = SETUP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      sel_q   <= SEL_NONE;
      ch_q    <= '0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == SETUP) begin
        cnt     <= '0;
        sel_q   <= sel;
        ch_q    <= ch;
        err_q   <= err;
        write_q <= PWRITE;
        rdata_q <= rval;
      end else if ((state == ACCESS) && !ready) begin
        cnt <= cnt + 3'd1;
      end
    end
  end

  assign id_ovf   = PWDATA >= 32'(DEPTH);
  assign load_val = id_ovf ? '0 : PWDATA[PW-1:0];

  always_comb begin
    load    = '0;
    advance = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      load[c]    = wr_ok && (sel_q == SEL_ID) && (ch_q == 3'(c));
      advance[c] = complete && !write_q && !err_q && (sel_q == SEL_ID) &&
                   (ch_q == 3'(c)) && ctrl[c];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    id_channel #(.DEPTH(DEPTH)) u_ch (
      .clk      (PCLK),
      .rst      (PRESET),
      .load     (load[c]),
      .load_val (load_val),
      .advance  (advance[c]),
      .ptr      (ptrs[c]),
      .wrap     (wrap[c])
    );
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ctrl    <= '1;
      scratch <= W_RESET;
      status  <= '0;
    end else begin
      if (wr_ok && (sel_q == SEL_CTRL))    ctrl    <= PWDATA[NUM_CH-1:0];
      if (wr_ok && (sel_q == SEL_SCRATCH)) scratch <= PWDATA;
      status <= ((wr_ok && (sel_q == SEL_STATUS)) ? (status & ~PWDATA[NUM_CH-1:0]) : status)
                | wrap;
    end
  end

  assign PREADY  = ready;
  assign PRDATA  = ready ? rdata_q : '0;
  assign PSLVERR = ready && (err_q || (write_q && (sel_q == SEL_ID) && id_ovf));

endmodule

// File: tb/tb_apb_id_bank.sv
// Bench for apb_id_bank: two instances (0 and 3 wait states) against a behavioural register model.
module tb_apb_id_bank;

  localparam int          NUM_CH  = 4;
  localparam int          DEPTH   = 10;
  localparam logic [31:0] ID_BASE = 32'hA0;
  localparam logic [31:0] R_VALUE = 32'h00FF0000;
  localparam logic [31:0] W_RESET = 32'h00CCCAA0;
  localparam int          WS0     = 0;
  localparam int          WS1     = 3;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [31:0] paddr, pwdata;
  logic        pwrite, penable;
  logic        psel    [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  always #5 PCLK = ~PCLK;

  apb_id_bank #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .ID_BASE(ID_BASE), .WAIT_STATES(WS0),
                .R_VALUE(R_VALUE), .W_RESET(W_RESET)) dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
    .PSEL(psel[0]), .PENABLE(penable), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]));

  apb_id_bank #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .ID_BASE(ID_BASE), .WAIT_STATES(WS1),
                .R_VALUE(R_VALUE), .W_RESET(W_RESET)) dut1 (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
    .PSEL(psel[1]), .PENABLE(penable), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]));

  int unsigned m_ptr     [2][NUM_CH];
  logic [31:0] m_ctrl    [2];
  logic [31:0] m_scratch [2];
  logic [31:0] m_status  [2];
  bit          hot       [2];
  int          checks;
  int          errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NUM_CH; c++) m_ptr[d][c] = 0;
      m_ctrl[d]    = 32'((1 << NUM_CH) - 1);
      m_scratch[d] = W_RESET;
      m_status[d]  = '0;
      hot[d]       = 1'b0;
    end
  endfunction

  // Register-level behaviour of one completed transfer.
  function automatic void model_xfer(input int d, input logic [31:0] addr, input logic wr,
                                     input logic [31:0] wdata,
                                     output logic [31:0] er, output logic ee);
    int unsigned o;
    int unsigned c;
    o  = {20'b0, addr[11:0]};
    er = '0;
    ee = 1'b0;
    if (o % 4 != 0) begin
      ee = 1'b1;
    end else if (o < 4 * NUM_CH) begin
      c = o / 4;
      if (wr) begin
        if (wdata < 32'(DEPTH)) m_ptr[d][c] = wdata;
        else begin
          m_ptr[d][c] = 0;
          ee = 1'b1;
        end
      end else begin
        er = ID_BASE + 32'(16 * c) + 32'(m_ptr[d][c]);
        if (m_ctrl[d][c]) begin
          m_ptr[d][c] = m_ptr[d][c] + 1;
          if (m_ptr[d][c] == DEPTH) begin
            m_ptr[d][c] = 0;
            m_status[d][c] = 1'b1;
          end
        end
      end
    end else if (o == 32'h100) begin
      if (wr) m_ctrl[d] = wdata & 32'((1 << NUM_CH) - 1);
      else    er = m_ctrl[d];
    end else if (o == 32'h104) begin
      if (wr) m_scratch[d] = wdata;
      else    er = m_scratch[d];
    end else if (o == 32'h108) begin
      if (wr) ee = 1'b1;
      else    er = R_VALUE;
    end else if (o == 32'h10C) begin
      if (wr) m_status[d] = m_status[d] & ~wdata;
      else    er = m_status[d];
    end else begin
      ee = 1'b1;
    end
  endfunction

  // Transfer is setup + WAIT_STATES+1 access cycles; one extra FSM cycle when starting from idle.
  task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wdata, output logic [31:0] rd);
    logic [31:0] er;
    logic        ee;
    int          exp_wait;
    int          w;
    bit          idle_ok;
    bit          timed_out;
    exp_wait = (d == 0 ? WS0 : WS1) + (hot[d] ? 0 : 1);
    model_xfer(d, addr, wr, wdata, er, ee);
    @(negedge PCLK);
    psel[0] = 1'b0; psel[1] = 1'b0; psel[d] = 1'b1;
    penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata;
    hot[1-d] = 1'b0;
    @(negedge PCLK);
    penable   = 1'b1;
    w         = 0;
    idle_ok   = 1'b1;
    timed_out = 1'b0;
    while (pready[d] !== 1'b1) begin
      if (prdata[d] !== 32'h0 || pslverr[d] !== 1'b0) idle_ok = 1'b0;
      if (w == 40) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge PCLK);
      w++;
    end
    check("timeout", 32'(timed_out), 32'd0);
    check("wait_cycles", 32'(w), 32'(exp_wait));
    check("outputs_zero_while_waiting", 32'(idle_ok), 32'd1);
    check("pslverr", 32'(pslverr[d]), 32'(ee));
    if (!wr) check("prdata", prdata[d], er);
    rd = prdata[d];
    @(posedge PCLK);
    #1;
    hot[d] = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge PCLK);
      psel[0] = 1'b0; psel[1] = 1'b0; penable = 1'b0;
    end
    hot[0] = 1'b0;
    hot[1] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] addr, wdata;
    logic        wr;
    int          d, k;

    checks = 0; errors = 0;
    PRESET = 1'b1;
    psel[0] = 1'b0; psel[1] = 1'b0; penable = 1'b0;
    paddr = '0; pwdata = '0; pwrite = 1'b0;
    model_reset();
    repeat (2) @(negedge PCLK);
    for (int i = 0; i < 2; i++) begin
      check("reset_prdata", prdata[i], 32'h0);
      check("reset_pready", 32'(pready[i]), 32'd0);
      check("reset_pslverr", 32'(pslverr[i]), 32'd0);
    end
    PRESET = 1'b0;

    for (int i = 0; i < 11; i++) xfer(0, 32'h000, 1'b0, '0, rd);
    check("id0_after_wrap", rd, 32'hA0);
    xfer(0, 32'h10C, 1'b0, '0, rd);
    check("status_wrap0", rd, 32'h1);

    xfer(0, 32'h008, 1'b1, 32'd3, rd);
    xfer(0, 32'h008, 1'b0, '0, rd);
    check("id2_first", rd, 32'hC3);
    xfer(0, 32'h008, 1'b0, '0, rd);
    check("id2_second", rd, 32'hC4);
    xfer(0, 32'h008, 1'b1, 32'd12, rd);
    xfer(0, 32'h008, 1'b0, '0, rd);
    check("id2_after_bad_load", rd, 32'hC0);
    xfer(0, 32'h00C, 1'b1, 32'd9, rd);
    xfer(0, 32'h00C, 1'b0, '0, rd);
    check("id3_last_entry", rd, 32'hD9);
    xfer(0, 32'h00C, 1'b1, 32'd10, rd);

    xfer(0, 32'h100, 1'b1, 32'hE, rd);
    xfer(0, 32'h000, 1'b1, 32'd0, rd);
    for (int i = 0; i < 3; i++) begin
      xfer(0, 32'h000, 1'b0, '0, rd);
      check("id0_static", rd, 32'hA0);
    end

    xfer(0, 32'h108, 1'b1, 32'h1234, rd);
    idle(1);
    xfer(0, 32'h200, 1'b0, '0, rd);
    xfer(0, 32'h102, 1'b0, '0, rd);
    xfer(0, 32'h108, 1'b0, '0, rd);
    check("ro_value", rd, 32'h00FF0000);

    xfer(1, 32'h104, 1'b0, '0, rd);
    check("scratch_reset", rd, 32'h00CCCAA0);
    xfer(1, 32'h104, 1'b1, 32'h5A5AF00D, rd);
    idle(2);
    xfer(1, 32'h104, 1'b0, '0, rd);
    check("scratch_written", rd, 32'h5A5AF00D);

    // Reset while an ID1 read is presenting data.
    xfer(0, 32'h004, 1'b1, 32'd5, rd);
    idle(1);
    @(negedge PCLK);
    psel[0] = 1'b1; penable = 1'b0; paddr = 32'h004; pwrite = 1'b0;
    @(negedge PCLK);
    penable = 1'b1;
    @(negedge PCLK);
    check("pre_reset_pready", 32'(pready[0]), 32'd1);
    check("pre_reset_prdata", prdata[0], 32'hB5);
    #1 PRESET = 1'b1;
    #1;
    check("mid_reset_pready", 32'(pready[0]), 32'd0);
    check("mid_reset_prdata", prdata[0], 32'h0);
    @(negedge PCLK);
    psel[0] = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b0;
    model_reset();
    xfer(0, 32'h004, 1'b0, '0, rd);
    check("id1_after_reset", rd, 32'hB0);
    xfer(0, 32'h10C, 1'b0, '0, rd);
    check("status_after_reset", rd, 32'h0);

    for (int i = 0; i < 400; i++) begin
      d     = int'($urandom_range(0, 1));
      k     = int'($urandom_range(0, 9));
      wr    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      case (k)
        0, 1, 2: begin
          addr  = 32'(4 * $urandom_range(0, 7));
          wdata = 32'($urandom_range(0, 15));
        end
        3: addr = 32'h100;
        4: addr = 32'h104;
        5: addr = 32'h108;
        6: addr = 32'h10C;
        7: addr = ($urandom_range(0, 1) != 0) ? 32'h110 : 32'h200;
        default: addr = 32'(4 * $urandom_range(0, 3)) | 32'($urandom_range(1, 3));
      endcase
      if ($urandom_range(0, 3) == 0) addr = addr | ($urandom & 32'hFFFFF000);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      xfer(d, addr, wr, wdata, rd);
    end

    idle(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
